eflags_wb: RTL and testbench

//  Architectural EFLAGS register at the writeback end of the execute/flags path.
//  - Consumes the 6-bit flag result vector and per-flag load enables from the ALU pipeline latch.
//  - Commits POPF images, and saves/restores flags on ISR entry and IRET through a shadow stack.
//  - Returns CF/AF/DF to the execute stage as CF_in/AF_in/DF_in, plus the packed 32-bit EFLAGS image.

---
 rtl/eflags_wb_pkg.sv | 35 +++
 rtl/eflags_wb_pack.sv | 41 ++++
 rtl/eflags_wb.sv | 135 +++++++++++++
 tb/tb_eflags_wb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/eflags_wb_pkg.sv
// Shared constants for the EFLAGS writeback block: image bit positions,
// internal 7-flag vector layout and shadow-stack FSM encodings.
package eflags_wb_pkg;

    localparam int unsigned IMG_W   = 32;
    localparam int unsigned FLG6_W  = 6;
    localparam int unsigned FLG7_W  = 7;
    localparam int unsigned DEPTH_W = 3;

    // Bit positions inside the packed 32-bit EFLAGS image
    localparam int unsigned BIT_CF    = 0;
    localparam int unsigned BIT_RSVD1 = 1;
    localparam int unsigned BIT_PF    = 2;
    localparam int unsigned BIT_AF    = 4;
    localparam int unsigned BIT_ZF    = 6;
    localparam int unsigned BIT_SF    = 7;
    localparam int unsigned BIT_DF    = 10;
    localparam int unsigned BIT_OF    = 11;

    // Internal 7-flag vector; bits 5:0 match the {OF,SF,ZF,AF,PF,CF} pipeline order
    localparam int unsigned F_CF = 0;
    localparam int unsigned F_PF = 1;
    localparam int unsigned F_AF = 2;
    localparam int unsigned F_ZF = 3;
    localparam int unsigned F_SF = 4;
    localparam int unsigned F_OF = 5;
    localparam int unsigned F_DF = 6;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } nest_state_e;

endpackage

// File: rtl/eflags_wb_pack.sv
// Pure wiring between the internal 7-flag vector and the 32-bit EFLAGS image.
module eflags_pack
    import eflags_wb_pkg::*;
(
    input  logic [FLG7_W-1:0] flags_in,
    output logic [IMG_W-1:0]  image_out,
    input  logic [IMG_W-1:0]  image_in,
    output logic [FLG7_W-1:0] flags_out
);

    // Bits outside the architectural flag set are intentionally dropped
    logic unused_image_bits;
    assign unused_image_bits = ^{image_in[31:12], image_in[9:8], image_in[5],
                                 image_in[3], image_in[1]};

    // Pack: reserved bit 1 reads as one, everything else unused reads as zero
    always_comb begin
        image_out            = '0;
        image_out[BIT_RSVD1] = 1'b1;
        image_out[BIT_CF]    = flags_in[F_CF];
        image_out[BIT_PF]    = flags_in[F_PF];
        image_out[BIT_AF]    = flags_in[F_AF];
        image_out[BIT_ZF]    = flags_in[F_ZF];
        image_out[BIT_SF]    = flags_in[F_SF];
        image_out[BIT_DF]    = flags_in[F_DF];
        image_out[BIT_OF]    = flags_in[F_OF];
    end

    // Unpack: pick the seven architectural flags out of a POPF image
    always_comb begin
        flags_out       = '0;
        flags_out[F_CF] = image_in[BIT_CF];
        flags_out[F_PF] = image_in[BIT_PF];
        flags_out[F_AF] = image_in[BIT_AF];
        flags_out[F_ZF] = image_in[BIT_ZF];
        flags_out[F_SF] = image_in[BIT_SF];
        flags_out[F_DF] = image_in[BIT_DF];
        flags_out[F_OF] = image_in[BIT_OF];
    end

endmodule

// File: rtl/eflags_wb.sv
// Architectural EFLAGS register with POPF commit and an ISR shadow stack.
// Optional macro EFLAGS_BYPASS_EN: forward next-state CF/AF/DF to execute.
module eflags_wb
    import eflags_wb_pkg::*;
#(
    parameter int unsigned NEST_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_valid,
    input  logic               wb_stall,
    input  logic [FLG6_W-1:0]  wb_flags,
    input  logic [FLG6_W-1:0]  wb_ld_flags,
    input  logic               wb_cmps_sel,
    input  logic [FLG6_W-1:0]  wb_cmps_flags,
    input  logic               wb_ld_df,
    input  logic               wb_df_val,
    input  logic               wb_popf,
    input  logic [IMG_W-1:0]   wb_popf_data,
    input  logic               isr_enter,
    input  logic               iret,
    output logic [IMG_W-1:0]   eflags,
    output logic               cf_out,
    output logic               af_out,
    output logic               df_out,
    output logic [DEPTH_W-1:0] nest_depth,
    output logic               nest_err
);

    logic [FLG7_W-1:0]  flags_q, flags_d;
    logic [FLG7_W-1:0]  stack_q [NEST_DEPTH];
    logic [FLG7_W-1:0]  stack_d [NEST_DEPTH];
    nest_state_e        state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               nest_err_q, nest_err_d;

    logic               commit, push_req, pop_req;
    logic               push_ok, pop_ok, err_evt;
    logic [DEPTH_W-1:0] wr_idx;
    logic [FLG6_W-1:0]  src;
    logic [FLG7_W-1:0]  upd, top_entry, popf_flags;

    assign commit   = wb_valid & ~wb_stall;
    assign push_req = isr_enter & ~wb_stall;
    assign pop_req  = iret & ~wb_stall;

    eflags_pack u_pack (
        .flags_in  (flags_q),
        .image_out (eflags),
        .image_in  (wb_popf_data),
        .flags_out (popf_flags)
    );

    // Read the current top-of-stack entry (none when empty)
    always_comb begin
        top_entry = '0;
        for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
            if (DEPTH_W'(i) == depth_q - DEPTH_W'(1)) top_entry = stack_q[i];
        end
    end

    // Flag next state: commit update or POPF, then a successful pop overrides
    always_comb begin
        src = wb_cmps_sel ? wb_cmps_flags : wb_flags;
        upd = flags_q;
        if (commit) begin
            if (wb_popf) begin
                upd = popf_flags;
            end else begin
                for (int unsigned i = 0; i < FLG6_W; i++) begin
                    if (wb_ld_flags[i]) upd[i] = src[i];
                end
                if (wb_ld_df) upd[F_DF] = wb_df_val;
            end
        end
        flags_d = pop_ok ? top_entry : upd;
    end

    // FSM outputs: which stack operations actually happen this cycle
    always_comb begin
        pop_ok  = pop_req && (state_q != ST_EMPTY);
        push_ok = push_req && ((state_q != ST_FULL) || pop_ok);
        wr_idx  = pop_ok ? depth_q - DEPTH_W'(1) : depth_q;
        err_evt = (pop_req && (state_q == ST_EMPTY)) || (push_req && !push_ok);
    end

    // FSM next state: depth, occupancy state, sticky error and stack contents
    always_comb begin
        depth_d = depth_q;
        case ({push_ok, pop_ok})
            2'b10:   depth_d = depth_q + DEPTH_W'(1);
            2'b01:   depth_d = depth_q - DEPTH_W'(1);
            default: depth_d = depth_q;
        endcase
        if (depth_d == '0)                         state_d = ST_EMPTY;
        else if (depth_d == DEPTH_W'(NEST_DEPTH))  state_d = ST_FULL;
        else                                       state_d = ST_ACTIVE;
        nest_err_d = nest_err_q | err_evt;
        for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
            stack_d[i] = stack_q[i];
            if (push_ok && (wr_idx == DEPTH_W'(i))) stack_d[i] = flags_d;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q    <= '0;
            state_q    <= ST_EMPTY;
            depth_q    <= '0;
            nest_err_q <= 1'b0;
            for (int unsigned i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            flags_q    <= flags_d;
            state_q    <= state_d;
            depth_q    <= depth_d;
            nest_err_q <= nest_err_d;
            for (int unsigned i = 0; i < NEST_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign nest_depth = depth_q;
    assign nest_err   = nest_err_q;

`ifdef EFLAGS_BYPASS_EN
    assign cf_out = flags_d[F_CF];
    assign af_out = flags_d[F_AF];
    assign df_out = flags_d[F_DF];
`else
    assign cf_out = flags_q[F_CF];
    assign af_out = flags_q[F_AF];
    assign df_out = flags_q[F_DF];
`endif

endmodule

// File: tb/tb_eflags_wb.sv
// Directed bench for eflags_wb: flag commit, POPF, DF, CMPS select, shadow stack.
module tb_eflags_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_stall, wb_cmps_sel, wb_ld_df, wb_df_val, wb_popf;
    logic [5:0]  wb_flags, wb_ld_flags, wb_cmps_flags;
    logic [31:0] wb_popf_data;
    logic        isr_enter, iret;
    logic [31:0] eflags;
    logic        cf_out, af_out, df_out;
    logic [2:0]  nest_depth;
    logic        nest_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eflags_wb #(.NEST_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_stall(wb_stall),
        .wb_flags(wb_flags), .wb_ld_flags(wb_ld_flags),
        .wb_cmps_sel(wb_cmps_sel), .wb_cmps_flags(wb_cmps_flags),
        .wb_ld_df(wb_ld_df), .wb_df_val(wb_df_val),
        .wb_popf(wb_popf), .wb_popf_data(wb_popf_data),
        .isr_enter(isr_enter), .iret(iret),
        .eflags(eflags), .cf_out(cf_out), .af_out(af_out), .df_out(df_out),
        .nest_depth(nest_depth), .nest_err(nest_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_valid = 0; wb_stall = 0; wb_flags = '0; wb_ld_flags = '0;
        wb_cmps_sel = 0; wb_cmps_flags = '0; wb_ld_df = 0; wb_df_val = 0;
        wb_popf = 0; wb_popf_data = '0; isr_enter = 0; iret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic commit(input logic [5:0] f, input logic [5:0] ld);
        wb_valid = 1; wb_flags = f; wb_ld_flags = ld;
    endtask

    initial begin
        idle();
        rst_n = 0;
        commit(6'h3F, 6'h3F);
        tick();
        rst_n = 1;
        chk("reset_eflags", eflags, 32'h2);
        chk("reset_depth", 32'(nest_depth), 32'd0);
        chk("reset_err", 32'(nest_err), 32'd0);

        // CF and AF loaded only
        commit(6'b111111, 6'b000101); tick();
        chk("ld_cf_af", eflags, 32'h13);
        chk("ld_af_out", 32'(af_out), 32'd1);
        commit(6'b000000, 6'b111111); wb_stall = 1; tick();
        chk("stall_hold", eflags, 32'h13);
        wb_flags = 6'b000000; wb_ld_flags = 6'b111111; wb_ld_df = 1; wb_df_val = 1; tick();
        chk("no_valid_hold", eflags, 32'h13);

        // POPF beats the per-flag loads
        commit(6'b000000, 6'b111111); wb_popf = 1; wb_popf_data = 32'h0000_0CD5; tick();
        chk("popf", eflags, 32'h0000_0CD7);
        chk("popf_df_out", 32'(df_out), 32'd1);

        wb_valid = 1; wb_ld_df = 1; wb_df_val = 0; tick();
        chk("cld", eflags, 32'h0000_08D7);

        commit(6'b111111, 6'b111111); wb_cmps_sel = 1; wb_cmps_flags = 6'b000001; tick();
        chk("cmps_sel", eflags, 32'h3);

        // Single save / restore
        isr_enter = 1; tick();
        chk("push1_depth", 32'(nest_depth), 32'd1);
        commit(6'b000000, 6'b000001); tick();
        chk("clear_cf", eflags, 32'h2);
        iret = 1; tick();
        chk("iret_restore", eflags, 32'h3);
        chk("iret_depth", 32'(nest_depth), 32'd0);

        // Stall blocks isr_enter
        isr_enter = 1; wb_stall = 1; tick();
        chk("stall_push", 32'(nest_depth), 32'd0);

        // Nesting overflow: second push carries same-cycle commit (ZF only)
        isr_enter = 1; tick();
        isr_enter = 1; commit(6'b001000, 6'b001001); tick();
        chk("push_post_upd", eflags, 32'h42);
        chk("depth2", 32'(nest_depth), 32'd2);
        chk("err_before_ovf", 32'(nest_err), 32'd0);
        isr_enter = 1; tick();
        chk("ovf_depth", 32'(nest_depth), 32'd2);
        chk("ovf_err", 32'(nest_err), 32'd1);
        commit(6'b111111, 6'b111111); tick();
        chk("set_all", eflags, 32'h8D7);
        iret = 1; commit(6'b000000, 6'b111111); tick();
        chk("iret_beats_commit", eflags, 32'h42);
        iret = 1; tick();
        chk("pop2", eflags, 32'h3);
        chk("pop2_depth", 32'(nest_depth), 32'd0);
        chk("err_sticky", 32'(nest_err), 32'd1);
        iret = 1; tick();
        chk("extra_iret", eflags, 32'h3);
        chk("extra_depth", 32'(nest_depth), 32'd0);
        iret = 1; commit(6'b000000, 6'b000001); tick();
        chk("empty_iret_commit", eflags, 32'h2);

        // Simultaneous pop + push writes the restored value back
        isr_enter = 1; tick();
        commit(6'b000001, 6'b000001); tick();
        isr_enter = 1; tick();
        commit(6'b000000, 6'b000001); tick();
        isr_enter = 1; iret = 1; tick();
        chk("swap_flags", eflags, 32'h3);
        chk("swap_depth", 32'(nest_depth), 32'd2);
        commit(6'b001000, 6'b001000); tick();
        chk("set_zf", eflags, 32'h43);
        iret = 1; tick();
        chk("swap_pop1", eflags, 32'h3);
        iret = 1; tick();
        chk("swap_pop2", eflags, 32'h2);
        chk("swap_depth0", 32'(nest_depth), 32'd0);

        // Forwarding of CF to execute
        commit(6'b000001, 6'b000001);
        #1;
`ifdef EFLAGS_BYPASS_EN
        chk("cf_same_cycle", 32'(cf_out), 32'd1);
`else
        chk("cf_same_cycle", 32'(cf_out), 32'd0);
`endif
        tick();
        chk("cf_next_cycle", 32'(cf_out), 32'd1);

        // Reset clears the sticky error and overrides inputs
        rst_n = 0; commit(6'h3F, 6'h3F); isr_enter = 1;
        @(posedge clk); #1; idle(); rst_n = 1;
        chk("reset2_eflags", eflags, 32'h2);
        chk("reset2_err", 32'(nest_err), 32'd0);
        chk("reset2_depth", 32'(nest_depth), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
